cwr_decoder: RTL and testbench

Control-word-register stage of the 8254 timer; sits directly upstream of the three `counter` instances. It captures bus writes to the control address and decodes the 8-bit control word. Each counter receives a per-counter `CWRmode` (6 bits) and a per-counter active-low `read_back` command pair. It also produces load strobes that tell a counter its mode was just reprogrammed.

---
 rtl/cwr_decoder.sv | 80 ++++++++
 tb/tb_cwr_decoder.sv | 130 +++++++++++++
 2 files changed

// File: rtl/cwr_decoder.sv
// cwr_decoder: 8254 control word register capture and per-counter decode
module cwr_decoder #(
    parameter logic [1:0] CWR_ADDR   = 2'b11,
    parameter logic [5:0] RESET_MODE = 6'b010000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] databus,
    input  logic [1:0] addrbus,
    input  logic       RWbus,
    input  logic       wr_strobe,
    output logic [5:0] CWRmode0,
    output logic [5:0] CWRmode1,
    output logic [5:0] CWRmode2,
    output logic [1:0] read_back0,
    output logic [1:0] read_back1,
    output logic [1:0] read_back2,
    output logic [2:0] cw_load,
    output logic [2:0] cw_valid,
    output logic       cmd_error
);
    logic [5:0] mode_q [3];
    logic [5:0] mode_d [3];
    logic [1:0] rb_q [3];
    logic [1:0] rb_d [3];
    logic [2:0] load_q, load_d, valid_q, valid_d;
    logic       err_q, err_d;
    logic       wr;
    logic [1:0] sc, rw;
    logic [2:0] m;

    assign wr = wr_strobe && !RWbus && addrbus == CWR_ADDR;
    assign sc = databus[7:6];
    assign rw = databus[5:4];
    // modes 6 and 7 are aliases of modes 2 and 3
    assign m  = (databus[3:2] == 2'b11) ? {1'b0, databus[2:1]} : databus[3:1];

    // decode one control word into next mode, pulse and sticky-valid values
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            load_d[i] = wr && sc == 2'(i) && rw != 2'b00;
            mode_d[i] = load_d[i] ? {rw, m, databus[0]} : mode_q[i];
            rb_d[i]   = (wr && sc == 2'(i) && rw == 2'b00) ? 2'b01 :
                        (wr && sc == 2'b11 && !databus[0] && databus[1+i]) ? rw : 2'b11;
        end
        valid_d = valid_q | load_d;
        err_d   = wr && sc == 2'b11 && databus[0];
    end

    // register state; reset overrides any write in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                mode_q[i] <= RESET_MODE;
                rb_q[i]   <= 2'b11;
            end
            load_q  <= 3'b000;
            valid_q <= 3'b000;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                mode_q[i] <= mode_d[i];
                rb_q[i]   <= rb_d[i];
            end
            load_q  <= load_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign CWRmode0   = mode_q[0];
    assign CWRmode1   = mode_q[1];
    assign CWRmode2   = mode_q[2];
    assign read_back0 = rb_q[0];
    assign read_back1 = rb_q[1];
    assign read_back2 = rb_q[2];
    assign cw_load    = load_q;
    assign cw_valid   = valid_q;
    assign cmd_error  = err_q;
endmodule

// File: tb/tb_cwr_decoder.sv
// tb_cwr_decoder: directed plus random checks of cwr_decoder against a behavioural model
module tb_cwr_decoder;
    logic       clk = 1'b0;
    logic       reset, RWbus, wr_strobe;
    logic [7:0] databus;
    logic [1:0] addrbus;
    logic [5:0] CWRmode0, CWRmode1, CWRmode2;
    logic [1:0] read_back0, read_back1, read_back2;
    logic [2:0] cw_load, cw_valid;
    logic       cmd_error;

    int checks = 0;
    int failures = 0;

    int em [3];
    int erb [3];
    int eload, evalid, eerr;

    cwr_decoder dut (
        .clk(clk), .reset(reset), .databus(databus), .addrbus(addrbus),
        .RWbus(RWbus), .wr_strobe(wr_strobe),
        .CWRmode0(CWRmode0), .CWRmode1(CWRmode1), .CWRmode2(CWRmode2),
        .read_back0(read_back0), .read_back1(read_back1), .read_back2(read_back2),
        .cw_load(cw_load), .cw_valid(cw_valid), .cmd_error(cmd_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input int expv);
        logic [7:0] e;
        e = 8'(expv);
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, e);
        end
    endtask

    // model computed directly from the control-word rules
    task automatic model(input logic st, input logic rwb, input logic [1:0] a, input logic [7:0] d, input logic r);
        int dv, sc, rwf, mn;
        dv = int'(d);
        for (int i = 0; i < 3; i++) erb[i] = 3;
        eload = 0;
        eerr = 0;
        if (r) begin
            for (int i = 0; i < 3; i++) em[i] = 16;
            evalid = 0;
        end else if (st && !rwb && a == 2'b11) begin
            sc = dv / 64;
            rwf = (dv / 16) % 4;
            if (sc < 3) begin
                if (rwf != 0) begin
                    mn = (dv / 2) % 8;
                    if (mn >= 6) mn -= 4;
                    em[sc] = rwf * 16 + mn * 2 + dv % 2;
                    eload = 1 << sc;
                    evalid = evalid | eload;
                end else erb[sc] = 1;
            end else if (dv % 2 == 1) eerr = 1;
            else for (int i = 0; i < 3; i++) if (((dv >> (1 + i)) & 1) == 1) erb[i] = rwf;
        end
    endtask

    task automatic step(input logic st, input logic rwb, input logic [1:0] a, input logic [7:0] d, input logic r);
        @(negedge clk);
        wr_strobe = st;
        RWbus = rwb;
        addrbus = a;
        databus = d;
        reset = r;
        @(posedge clk);
        #1;
        model(st, rwb, a, d, r);
        check("mode0", 8'(CWRmode0), em[0]);
        check("mode1", 8'(CWRmode1), em[1]);
        check("mode2", 8'(CWRmode2), em[2]);
        check("rb0", 8'(read_back0), erb[0]);
        check("rb1", 8'(read_back1), erb[1]);
        check("rb2", 8'(read_back2), erb[2]);
        check("cw_load", 8'(cw_load), eload);
        check("cw_valid", 8'(cw_valid), evalid);
        check("cmd_error", 8'(cmd_error), eerr);
    endtask

    task automatic wr(input logic [7:0] d);
        step(1'b1, 1'b0, 2'b11, d, 1'b0);
    endtask

    initial begin
        logic       st, rwb, r;
        logic [1:0] a;
        logic [7:0] d;
        step(1'b0, 1'b0, 2'b00, 8'h00, 1'b1);
        step(1'b0, 1'b0, 2'b00, 8'h00, 1'b0);
        check("reset_mode_const", 8'(CWRmode1), 16);
        wr(8'h74);
        check("mode1_74", 8'(CWRmode1), 8'h34);
        step(1'b0, 1'b0, 2'b11, 8'h00, 1'b0);
        wr(8'h9C);
        check("mode2_9c", 8'(CWRmode2), 8'h14);
        wr(8'h36);
        wr(8'h00);
        check("rb0_latch", 8'(read_back0), 1);
        step(1'b0, 1'b0, 2'b11, 8'h00, 1'b0);
        wr(8'hCE);
        check("rb1_readback", 8'(read_back1), 0);
        wr(8'hCF);
        check("err_cf", 8'(cmd_error), 1);
        wr(8'hFE);
        wr(8'hC0);
        wr(8'hDA);
        step(1'b1, 1'b1, 2'b11, 8'h34, 1'b0);
        step(1'b1, 1'b0, 2'b01, 8'h34, 1'b0);
        step(1'b0, 1'b0, 2'b11, 8'h34, 1'b0);
        wr(8'hCE);
        step(1'b1, 1'b0, 2'b11, 8'h74, 1'b1);
        step(1'b0, 1'b0, 2'b11, 8'h00, 1'b0);
        for (int n = 0; n < 400; n++) begin
            st  = ($urandom_range(0, 9) < 8);
            rwb = ($urandom_range(0, 9) == 0);
            a   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            d   = 8'($urandom);
            r   = ($urandom_range(0, 39) == 0);
            step(st, rwb, a, d, r);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
